// File: rtl/embeddedcpu_led_dimmer.sv
// PWM LED dimmer behind the LED PIO. Each led_in bit becomes a PWM-dimmed
// drive, with an optional linear fade between off and the programmed
// brightness. Software controls it through a 4-word Avalon-MM slave.

// One LED channel: its brightness level, the fade step toward its target,
// and the registered PWM compare.
module embeddedcpu_led_dimmer_ch (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       fade_en,
   input  logic       frame,
   input  logic       led_bit,
   input  logic [7:0] bright,
   input  logic [7:0] fade_step,
   input  logic [7:0] pwm_cnt,
   output logic       led_out
);
   logic [7:0] level;
   logic [7:0] target;
   logic [7:0] level_fade;
   logic [8:0] up_sum;
   logic [8:0] dn_diff;

   assign target  = led_bit ? bright : 8'd0;
   assign up_sum  = {1'b0, level} + {1'b0, fade_step};
   assign dn_diff = {1'b0, level} - {1'b0, fade_step};

   // One fade step toward target, computed at 9 bits and clamped so the
   // level lands exactly on target with no overshoot or wrap.
   always_comb begin
      level_fade = level;
      if (level < target) begin
         level_fade = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
      end else if (level > target) begin
         level_fade = (dn_diff[8] || (dn_diff[7:0] < target)) ? target : dn_diff[7:0];
      end
   end

   // Level tracking and PWM output register; disable parks the level at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level   <= 8'd0;
         led_out <= 1'b0;
      end else begin
         led_out <= enable && (pwm_cnt < level);
         if (!enable)       level <= 8'd0;
         else if (!fade_en) level <= target;
         else if (frame)    level <= level_fade;
      end
   end
endmodule

module embeddedcpu_led_dimmer #(
   parameter int WIDTH          = 10,
   parameter int PRESCALE_RESET = 49
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] led_in,
   output logic [WIDTH-1:0] led_out
);
   logic [1:0]  ctrl;
   logic [7:0]  bright;
   logic [15:0] prescale;
   logic [7:0]  fade_step;
   logic [15:0] psc;
   logic [7:0]  pwm_cnt;
   logic        wr_en;
   logic        tick;
   logic        frame;
   logic        enable;
   logic        fade_en;

   assign wr_en   = chipselect && !write_n;
   assign enable  = ctrl[0];
   assign fade_en = ctrl[1];
   assign tick    = (psc == prescale);
   assign frame   = tick && (pwm_cnt == 8'hFF);

   // Register file writes; upper writedata bits are dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl      <= 2'b01;
         bright    <= 8'd255;
         prescale  <= 16'(PRESCALE_RESET);
         fade_step <= 8'd1;
      end else if (wr_en) begin
         case (address)
            2'd0: ctrl      <= writedata[1:0];
            2'd1: bright    <= writedata[7:0];
            2'd2: prescale  <= writedata[15:0];
            2'd3: fade_step <= writedata[7:0];
            default: ;
         endcase
      end
   end

   // Zero-latency read mux, independent of chipselect.
   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0: readdata = {30'd0, ctrl};
         2'd1: readdata = {24'd0, bright};
         2'd2: readdata = {16'd0, prescale};
         2'd3: readdata = {24'd0, fade_step};
         default: readdata = 32'd0;
      endcase
   end

   // Prescaler and PWM frame counter. A PRESCALE write restarts the
   // prescaler so the new period starts cleanly; tick uses the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psc     <= 16'd0;
         pwm_cnt <= 8'd0;
      end else if (!enable) begin
         psc     <= 16'd0;
         pwm_cnt <= 8'd0;
      end else begin
         if (wr_en && address == 2'd2) psc <= 16'd0;
         else if (tick)                psc <= 16'd0;
         else                          psc <= psc + 16'd1;
         if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      embeddedcpu_led_dimmer_ch u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .enable    (enable),
         .fade_en   (fade_en),
         .frame     (frame),
         .led_bit   (led_in[i]),
         .bright    (bright),
         .fade_step (fade_step),
         .pwm_cnt   (pwm_cnt),
         .led_out   (led_out[i])
      );
   end
endmodule

// File: tb/tb_embeddedcpu_led_dimmer.sv
// Scoreboard bench for embeddedcpu_led_dimmer. Stimulus queues expected
// observations; the monitor pops them at the next falling edge and checks
// readdata, led_out, or per-channel on-counts over a 256-cycle window.
module tb_embeddedcpu_led_dimmer;
   localparam int WIDTH = 10;

   typedef enum {K_RD, K_LED, K_DUTY} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      logic [31:0] val;
      logic [9:0]  mask;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       address = 2'd0;
   logic             chipselect = 1'b0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = 32'd0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] led_in = '0;
   logic [WIDTH-1:0] led_out;

   exp_t q[$];
   bit   busy = 1'b0;
   bit   stim_done = 1'b0;
   int   tmo_cnt = 0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   cnt [WIDTH];

   embeddedcpu_led_dimmer #(.WIDTH(WIDTH), .PRESCALE_RESET(49)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_in     (led_in),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   task automatic push(input string n, input kind_e k, input logic [31:0] v, input logic [9:0] m);
      exp_t e;
      e.name = n; e.kind = k; e.val = v; e.mask = m;
      q.push_back(e);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         if (q.size() == 0 && !busy) return;
      end
      tmo_cnt++;
      $display("FAIL timeout: scoreboard not drained after %0d cycles, %0d left", bound, q.size());
   endtask

   // Bus write; returns 1ns after the capturing edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input string n, input logic [1:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      address = a;
      push(n, K_RD, v, '0);
      wait_idle(10);
   endtask

   task automatic duty(input string n, input int v, input logic [9:0] m);
      repeat (3) @(posedge clk);
      #1;
      push(n, K_DUTY, 32'(v), m);
      wait_idle(400);
   endtask

   // Monitor: pops one expectation per falling edge and checks it.
   initial begin : monitor
      exp_t e;
      bit ok;
      int bi;
      int want;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc > 60000) begin
            total++; bad++;
            $display("FAIL watchdog: got %0d cycles, want under 60000", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            busy = 1'b1;
            total++;
            case (e.kind)
               K_RD: if (readdata !== e.val) begin
                  bad++;
                  $display("FAIL %s: readdata got %08h want %08h", e.name, readdata, e.val);
               end
               K_LED: if (led_out !== e.val[WIDTH-1:0]) begin
                  bad++;
                  $display("FAIL %s: led_out got %03h want %03h", e.name, led_out, e.val[WIDTH-1:0]);
               end
               default: begin
                  for (int i = 0; i < WIDTH; i++) cnt[i] = int'(led_out[i]);
                  repeat (255) begin
                     @(negedge clk);
                     for (int i = 0; i < WIDTH; i++) cnt[i] += int'(led_out[i]);
                  end
                  ok = 1'b1; bi = 0; want = 0;
                  for (int i = WIDTH - 1; i >= 0; i--) begin
                     if (cnt[i] != (e.mask[i] ? int'(e.val) : 0)) begin
                        ok = 1'b0; bi = i; want = e.mask[i] ? int'(e.val) : 0;
                     end
                  end
                  if (!ok) begin
                     bad++;
                     $display("FAIL %s: ch%0d on-count got %0d want %0d", e.name, bi, cnt[bi], want);
                  end
               end
            endcase
            busy = 1'b0;
         end else if (stim_done) begin
            total += tmo_cnt;
            bad   += tmo_cnt;
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   // Stimulus
   initial begin : stim
      // Reset values, read with chipselect low.
      rd("rst_ctrl", 2'd0, 32'h1);
      rd("rst_bright", 2'd1, 32'hFF);
      rd("rst_prescale", 2'd2, 32'd49);
      rd("rst_fstep", 2'd3, 32'h1);
      @(posedge clk); #1; push("rst_led", K_LED, 32'h0, '0); wait_idle(10);
      @(posedge clk); #1; reset_n = 1'b1;

      // Upper writedata bits must be dropped.
      wr(2'd2, 32'hFFFF_0000);
      wr(2'd1, 32'h1234_5640);
      wr(2'd3, 32'h0000_0110);
      wr(2'd0, 32'hFFFF_FFFD);
      rd("mask_prescale", 2'd2, 32'h0);
      rd("mask_bright", 2'd1, 32'h40);
      rd("mask_fstep", 2'd3, 32'h10);
      rd("mask_ctrl", 2'd0, 32'h1);

      // Direct (no fade) duty at PRESCALE=0: on-count per 256 cycles = level.
      led_in = 10'h001;
      duty("duty64", 64, 10'h001);
      led_in = 10'h201;
      wr(2'd1, 32'd255);
      duty("duty255", 255, 10'h201);
      wr(2'd1, 32'd0);
      duty("bright0", 0, 10'h3FF);

      // Fade up to 200 in steps of 16, then down to 0. Re-enable aligns the
      // PWM frame so each 256-cycle window sees exactly one level.
      wr(2'd1, 32'd200);
      led_in = 10'h3FF;
      wr(2'd0, 32'd0);
      wr(2'd0, 32'd3);
      @(posedge clk); #1;
      for (int n = 0; n < 15; n++)
         push($sformatf("fade_up%0d", n), K_DUTY, 32'((16 * n > 200) ? 200 : 16 * n), 10'h3FF);
      repeat (3684) @(posedge clk);
      #1; led_in = 10'h000;
      for (int n = 15; n < 29; n++)
         push($sformatf("fade_dn%0d", n), K_DUTY, 32'((n >= 27) ? 0 : 200 - 16 * (n - 14)), 10'h3FF);
      wait_idle(8000);

      // Redirect mid-fade: at level 96 heading to 200, BRIGHT drops to 50.
      led_in = 10'h3FF;
      wr(2'd0, 32'd0);
      wr(2'd0, 32'd3);
      @(posedge clk); #1;
      for (int n = 0; n < 7; n++)
         push($sformatf("redir_up%0d", n), K_DUTY, 32'(16 * n), 10'h3FF);
      repeat (1636) @(posedge clk);
      wr(2'd1, 32'd50);
      push("redir7", K_DUTY, 32'd80, 10'h3FF);
      push("redir8", K_DUTY, 32'd64, 10'h3FF);
      push("redir9", K_DUTY, 32'd50, 10'h3FF);
      push("redir10", K_DUTY, 32'd50, 10'h3FF);
      wait_idle(2000);

      // Disable during active PWM, then re-enable and watch pwm_cnt restart.
      wr(2'd0, 32'd1);
      wr(2'd1, 32'd255);
      duty("full_duty", 255, 10'h3FF);
      wr(2'd0, 32'd0);
      @(posedge clk); #1; push("disable_off", K_LED, 32'h0, '0);
      wait_idle(10);
      wr(2'd0, 32'd1);
      push("reen_e0", K_LED, 32'h0, '0);
      @(posedge clk); #1; push("reen_e1", K_LED, 32'h0, '0);
      @(posedge clk); #1; push("reen_on", K_LED, 32'h3FF, '0);
      repeat (254) @(posedge clk);
      #1; push("pwm255_gap", K_LED, 32'h0, '0);
      @(posedge clk); #1; push("pwm_wrap_on", K_LED, 32'h3FF, '0);
      wait_idle(10);

      // Async reset while a fade is pending, PRESCALE=1000.
      wr(2'd2, 32'd1000);
      wr(2'd1, 32'd128);
      wr(2'd0, 32'd0);
      wr(2'd0, 32'd1);
      repeat (3) @(posedge clk);
      wr(2'd3, 32'd7);
      wr(2'd0, 32'd3);
      led_in = 10'h000;
      rd("pre_ctrl", 2'd0, 32'h3);
      rd("pre_bright", 2'd1, 32'd128);
      rd("pre_prescale", 2'd2, 32'd1000);
      rd("pre_fstep", 2'd3, 32'd7);
      @(posedge clk); #1; push("pre_reset_on", K_LED, 32'h3FF, '0);
      wait_idle(10);
      @(posedge clk); #1;
      reset_n = 1'b0;
      push("async_reset", K_LED, 32'h0, '0);
      wait_idle(10);
      rd("rst2_ctrl", 2'd0, 32'h1);
      rd("rst2_bright", 2'd1, 32'hFF);
      rd("rst2_prescale", 2'd2, 32'd49);
      rd("rst2_fstep", 2'd3, 32'h1);

      // Release together with a BRIGHT=1 write: led_out drops when the first
      // tick moves pwm_cnt to 1, 50 cycles after release.
      led_in = 10'h3FF;
      @(posedge clk); #1;
      reset_n = 1'b1;
      address = 2'd1; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      repeat (49) @(posedge clk);
      #1; push("tick_before", K_LED, 32'h3FF, '0);
      @(posedge clk); #1; push("tick_after", K_LED, 32'h0, '0);
      wait_idle(10);

      stim_done = 1'b1;
   end
endmodule
